// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//   Drives a row of N_LED board LEDs with a stepped pattern. A step happens every
//   (CLOCK_FREQ/STEP_HZ) << div_sel clock cycles while enabled. There are four
//   pattern modes: rotate-left, rotate-right, ping-pong and blink-all.
//
// Ports
//   clk      in   1              clock, all logic on posedge
//   rst      in   1              synchronous active-high reset
//   en       in   1              1 = run, 0 = pause (state held)
//   mode     in   2              0 rot-left, 1 rot-right, 2 ping-pong, 3 blink-all
//   div_sel  in   2              step period multiplier x1/x2/x4/x8
//   led      out  N_LED          LED drive, 1 = on (registered)
//   pos      out  $clog2(N_LED)  index of the lit LED in modes 0-2 (registered)
//   step     out  1              one-cycle pulse when led/pos update (registered)
// -----------------------------------------------------------------------------
module led_pattern_gen #(
   parameter int N_LED      = 8,
   parameter int CLOCK_FREQ = 50000000,
   parameter int STEP_HZ    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [1:0]                 mode,
   input  logic [1:0]                 div_sel,
   output logic [N_LED-1:0]           led,
   output logic [$clog2(N_LED)-1:0]   pos,
   output logic                       step
);

   localparam int STEP_CYC = CLOCK_FREQ / STEP_HZ;
   // Wide enough for the longest period minus one, (STEP_CYC << 3) - 1.
   localparam int CNT_W    = $clog2(STEP_CYC * 8);
   localparam int POS_W    = $clog2(N_LED);

   localparam logic [POS_W-1:0] POS_MAX    = POS_W'(N_LED - 1);
   localparam logic [POS_W-1:0] POS_MAX_M1 = POS_W'(N_LED - 2);
   localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
   localparam logic [N_LED-1:0] LED_ONE    = N_LED'(1);

   typedef enum logic [1:0] {
      MODE_ROTL  = 2'd0,
      MODE_ROTR  = 2'd1,
      MODE_PING  = 2'd2,
      MODE_BLINK = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   logic [CNT_W-1:0] cnt_q;
   logic [POS_W-1:0] pos_q, pos_d;
   dir_e             dir_q, dir_d;
   logic             phase_q, phase_d;
   mode_e            mode_q;
   logic [N_LED-1:0] led_q, led_d;
   logic             step_q;

   logic [CNT_W-1:0] limit_m1;
   logic             terminal;
   mode_e            mode_in;

   assign mode_in = mode_e'(mode);

   // Last count of the current period. The period ends on cnt >= limit-1 rather
   // than equality, so shortening div_sel mid-period ends the period on the next
   // edge instead of letting cnt run on and wrap.
   always_comb begin
      case (div_sel)
         2'd0:    limit_m1 = CNT_W'(STEP_CYC - 1);
         2'd1:    limit_m1 = CNT_W'(2 * STEP_CYC - 1);
         2'd2:    limit_m1 = CNT_W'(4 * STEP_CYC - 1);
         default: limit_m1 = CNT_W'(8 * STEP_CYC - 1);
      endcase
   end

   assign terminal = (cnt_q >= limit_m1);

   // Next pattern state, used only when a step is taken.
   // NOTE: every output of this block is assigned a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      pos_d   = pos_q;
      dir_d   = dir_q;
      phase_d = phase_q;
      led_d   = led_q;
      case (mode_q)
         MODE_ROTL: begin
            pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_ONE;
            led_d = LED_ONE << pos_d;
         end
         MODE_ROTR: begin
            pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_ONE;
            led_d = LED_ONE << pos_d;
         end
         MODE_PING: begin
            // Turn around at either end; the end LED is shown for a single step.
            if (dir_q == DIR_UP) begin
               if (pos_q == POS_MAX) begin
                  dir_d = DIR_DOWN;
                  pos_d = POS_MAX_M1;
               end else begin
                  pos_d = pos_q + POS_ONE;
               end
            end else begin
               if (pos_q == '0) begin
                  dir_d = DIR_UP;
                  pos_d = POS_ONE;
               end else begin
                  pos_d = pos_q - POS_ONE;
               end
            end
            led_d = LED_ONE << pos_d;
         end
         default: begin
            phase_d = ~phase_q;
            led_d   = {N_LED{~phase_q}};
         end
      endcase
   end

   // Priority: reset, then mode change (which also beats a pause and a terminal
   // count), then normal counting while enabled.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         pos_q   <= '0;
         dir_q   <= DIR_UP;
         phase_q <= 1'b0;
         mode_q  <= mode_in;
         led_q   <= LED_ONE;
         step_q  <= 1'b0;
      end else if (mode_in != mode_q) begin
         mode_q  <= mode_in;
         cnt_q   <= '0;
         pos_q   <= '0;
         dir_q   <= DIR_UP;
         phase_q <= 1'b0;
         step_q  <= 1'b0;
         led_q   <= (mode_in == MODE_BLINK) ? '0 : LED_ONE;
      end else if (en) begin
         if (terminal) begin
            cnt_q   <= '0;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            step_q  <= 1'b1;
         end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            step_q  <= 1'b0;
         end
      end else begin
         step_q <= 1'b0;
      end
   end

   assign led  = led_q;
   assign pos  = pos_q;
   assign step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
//   Directed bench for led_pattern_gen with N_LED=4, STEP_CYC=4. Expected step
//   results (led, pos, spacing in clocks since the previous wait) are queued as
//   stimulus is set up and compared as each step pulse appears.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic [1:0] div_sel;
   logic [3:0] led;
   logic [1:0] pos;
   logic       step;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0] led;
      logic [1:0] pos;
      int         gap;
   } exp_t;

   exp_t sb[$];

   led_pattern_gen #(
      .N_LED      (4),
      .CLOCK_FREQ (8),
      .STEP_HZ    (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode),
      .div_sel (div_sel),
      .led     (led),
      .pos     (pos),
      .step    (step)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_step(input logic [3:0] l, input logic [1:0] p, input int g);
      exp_t e;
      e.led = l;
      e.pos = p;
      e.gap = g;
      sb.push_back(e);
   endtask

   // Waits (bounded) for the next step pulse, sampled on negedges, and compares
   // it against the oldest queued expectation.
   task automatic wait_step(input string tag);
      exp_t e;
      int   n;
      e = sb.pop_front();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (step !== 1'b1 && n < 40);
      check($sformatf("%s.step", tag), {31'd0, step}, 32'd1);
      check($sformatf("%s.gap",  tag), n,              e.gap);
      check($sformatf("%s.led",  tag), {28'd0, led},   {28'd0, e.led});
      check($sformatf("%s.pos",  tag), {30'd0, pos},   {30'd0, e.pos});
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (sb.size() > 0) begin
         wait_step($sformatf("%s%0d", tag, k));
         k++;
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check($sformatf("%s.rst_led",  tag), {28'd0, led},  32'h1);
      check($sformatf("%s.rst_pos",  tag), {30'd0, pos},  32'h0);
      check($sformatf("%s.rst_step", tag), {31'd0, step}, 32'h0);
   endtask

   initial begin
      rst     = 1'b1;
      en      = 1'b1;
      mode    = 2'd0;
      div_sel = 2'd0;

      // 1: rotate-left
      do_reset("t1");
      expect_step(4'b0010, 2'd1, 4);
      expect_step(4'b0100, 2'd2, 4);
      expect_step(4'b1000, 2'd3, 4);
      expect_step(4'b0001, 2'd0, 4);
      drain("t1s");

      // 2: rotate-right
      mode = 2'd1;
      do_reset("t2");
      expect_step(4'b1000, 2'd3, 4);
      expect_step(4'b0100, 2'd2, 4);
      expect_step(4'b0010, 2'd1, 4);
      expect_step(4'b0001, 2'd0, 4);
      drain("t2s");

      // 3: ping-pong
      mode = 2'd2;
      do_reset("t3");
      expect_step(4'b0010, 2'd1, 4);
      expect_step(4'b0100, 2'd2, 4);
      expect_step(4'b1000, 2'd3, 4);
      expect_step(4'b0100, 2'd2, 4);
      expect_step(4'b0010, 2'd1, 4);
      expect_step(4'b0001, 2'd0, 4);
      expect_step(4'b0010, 2'd1, 4);
      drain("t3s");

      // 4: divider x4, then cut back to x1 at cnt=10
      mode    = 2'd0;
      div_sel = 2'd2;
      do_reset("t4");
      expect_step(4'b0010, 2'd1, 16);
      expect_step(4'b0100, 2'd2, 16);
      drain("t4a");
      repeat (10) @(negedge clk);
      div_sel = 2'd0;
      expect_step(4'b1000, 2'd3, 1);
      expect_step(4'b0001, 2'd0, 4);
      drain("t4b");

      // 5: pause mid-period, resume, then switch to blink-all mid-period
      do_reset("t5");
      expect_step(4'b0010, 2'd1, 4);
      drain("t5a");
      repeat (2) @(negedge clk);
      en = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("t5.pause_step", {31'd0, step}, 32'd0);
      end
      check("t5.pause_led", {28'd0, led}, 32'h2);
      check("t5.pause_pos", {30'd0, pos}, 32'h1);
      en = 1'b1;
      expect_step(4'b0100, 2'd2, 2);
      drain("t5b");
      @(negedge clk);
      mode = 2'd3;
      @(negedge clk);
      check("t5.blink_led",  {28'd0, led},  32'h0);
      check("t5.blink_pos",  {30'd0, pos},  32'h0);
      check("t5.blink_step", {31'd0, step}, 32'h0);
      expect_step(4'b1111, 2'd0, 4);
      expect_step(4'b0000, 2'd0, 4);
      expect_step(4'b1111, 2'd0, 4);
      drain("t5c");

      // 6: synchronous reset from led=0100
      mode = 2'd0;
      do_reset("t6");
      expect_step(4'b0010, 2'd1, 4);
      expect_step(4'b0100, 2'd2, 4);
      drain("t6s");
      rst = 1'b1;
      #1;
      check("t6.pre_edge_led", {28'd0, led}, 32'h4);
      check("t6.pre_edge_pos", {30'd0, pos}, 32'h2);
      @(negedge clk);
      rst = 1'b0;
      check("t6.post_led",  {28'd0, led},  32'h1);
      check("t6.post_pos",  {30'd0, pos},  32'h0);
      check("t6.post_step", {31'd0, step}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
